// File: rtl/memory_game_ctrl.sv
// memory_game_ctrl: 4x4 memory-card game controller.
// Ports: clk, reset (sync, active-high); btn_up/down/left/right/sel
// one-cycle pulses; cursor (slot), face_up/matched (16 slot masks),
// pairs_found, moves (saturating), game_done, state (debug).
module memory_game_ctrl #(
   parameter int unsigned HOLD_CYCLES = 25_000_000,
   parameter logic [63:0] LAYOUT      = 64'h7654_3210_7654_3210
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_sel,
   output logic [3:0]  cursor,
   output logic [15:0] face_up,
   output logic [15:0] matched,
   output logic [3:0]  pairs_found,
   output logic [7:0]  moves,
   output logic        game_done,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ONE_UP  = 3'd1,
      COMPARE = 3'd2,
      HOLD    = 3'd3,
      DONE    = 3'd4
   } state_t;

   localparam logic [24:0] HOLD_LOAD = 25'(HOLD_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cursor_q, cursor_d;
   logic [15:0] face_q, face_d;
   logic [15:0] match_q, match_d;
   logic [3:0]  pairs_q, pairs_d;
   logic [7:0]  moves_q, moves_d;
   logic        done_q, done_d;
   logic [3:0]  first_q, first_d;
   logic [3:0]  second_q, second_d;
   logic [24:0] hold_q, hold_d;

   logic [1:0]  row, col;
   logic [3:0]  id_first, id_second;
   logic        sel_ok;

   assign row       = cursor_q[3:2];
   assign col       = cursor_q[1:0];
   assign id_first  = LAYOUT[{first_q, 2'b00} +: 4];
   assign id_second = LAYOUT[{second_q, 2'b00} +: 4];
   // a face-up slot is either the pending first card or matched
   assign sel_ok    = btn_sel && !face_q[cursor_q];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cursor_q <= 4'd0;
         face_q   <= 16'd0;
         match_q  <= 16'd0;
         pairs_q  <= 4'd0;
         moves_q  <= 8'd0;
         done_q   <= 1'b0;
         first_q  <= 4'd0;
         second_q <= 4'd0;
         hold_q   <= 25'd0;
      end else begin
         state_q  <= state_d;
         cursor_q <= cursor_d;
         face_q   <= face_d;
         match_q  <= match_d;
         pairs_q  <= pairs_d;
         moves_q  <= moves_d;
         done_q   <= done_d;
         first_q  <= first_d;
         second_q <= second_d;
         hold_q   <= hold_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cursor_d = cursor_q;
      face_d   = face_q;
      match_d  = match_q;
      pairs_d  = pairs_q;
      moves_d  = moves_q;
      done_d   = done_q;
      first_d  = first_q;
      second_d = second_q;
      hold_d   = hold_q;

      // only one move per cycle: up > down > left > right
      if (state_q != DONE) begin
         if (btn_up)
            cursor_d = {row - 2'd1, col};
         else if (btn_down)
            cursor_d = {row + 2'd1, col};
         else if (btn_left)
            cursor_d = {row, col - 2'd1};
         else if (btn_right)
            cursor_d = {row, col + 2'd1};
      end

      case (state_q)
         IDLE: begin
            if (sel_ok) begin
               first_d          = cursor_q;
               face_d[cursor_q] = 1'b1;
               state_d          = ONE_UP;
            end
         end
         ONE_UP: begin
            if (sel_ok) begin
               second_d         = cursor_q;
               face_d[cursor_q] = 1'b1;
               state_d          = COMPARE;
            end
         end
         COMPARE: begin
            if (moves_q != 8'hFF)
               moves_d = moves_q + 8'd1;
            if (id_first == id_second) begin
               match_d[first_q]  = 1'b1;
               match_d[second_q] = 1'b1;
               pairs_d           = pairs_q + 4'd1;
               if (pairs_q == 4'd7) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               hold_d  = HOLD_LOAD;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (hold_q == 25'd0) begin
               face_d[first_q]  = 1'b0;
               face_d[second_q] = 1'b0;
               state_d          = IDLE;
            end else begin
               hold_d = hold_q - 25'd1;
            end
         end
         DONE: begin
            // restart keeps the cursor where the player left it
            if (btn_sel) begin
               state_d  = IDLE;
               face_d   = 16'd0;
               match_d  = 16'd0;
               pairs_d  = 4'd0;
               moves_d  = 8'd0;
               done_d   = 1'b0;
               first_d  = 4'd0;
               second_d = 4'd0;
               hold_d   = 25'd0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign cursor      = cursor_q;
   assign face_up     = face_q;
   assign matched     = match_q;
   assign pairs_found = pairs_q;
   assign moves       = moves_q;
   assign game_done   = done_q;
   assign state       = state_q;

endmodule

// File: tb/tb_memory_game_ctrl.sv
// tb_memory_game_ctrl: directed bench for memory_game_ctrl.
// Runs with HOLD_CYCLES=10 and the default layout.
module tb_memory_game_ctrl;

   localparam int H = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        btn_up = 1'b0;
   logic        btn_down = 1'b0;
   logic        btn_left = 1'b0;
   logic        btn_right = 1'b0;
   logic        btn_sel = 1'b0;
   logic [3:0]  cursor;
   logic [15:0] face_up;
   logic [15:0] matched;
   logic [3:0]  pairs_found;
   logic [7:0]  moves;
   logic        game_done;
   logic [2:0]  state;

   int errors = 0;
   int checks = 0;
   int exp_cur = 0;

   memory_game_ctrl #(.HOLD_CYCLES(H)) dut (
      .clk(clk),
      .reset(reset),
      .btn_up(btn_up),
      .btn_down(btn_down),
      .btn_left(btn_left),
      .btn_right(btn_right),
      .btn_sel(btn_sel),
      .cursor(cursor),
      .face_up(face_up),
      .matched(matched),
      .pairs_found(pairs_found),
      .moves(moves),
      .game_done(game_done),
      .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic u, input logic d, input logic l,
                        input logic r, input logic s);
      btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_sel = s;
      tick();
      btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_sel = 0;
   endtask

   task automatic sel();
      pulse(0, 0, 0, 0, 1);
   endtask

   task automatic go_to(input int slot);
      int downs;
      int rights;
      downs  = ((slot >> 2) - (exp_cur >> 2) + 4) % 4;
      rights = ((slot & 3) - (exp_cur & 3) + 4) % 4;
      for (int i = 0; i < downs; i++) pulse(0, 1, 0, 0, 0);
      for (int i = 0; i < rights; i++) pulse(0, 0, 0, 1, 0);
      exp_cur = slot;
      chk("goto_cursor", 32'(cursor), 32'(slot));
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      exp_cur = 0;
      chk({tag, "_cursor"}, 32'(cursor), 0);
      chk({tag, "_face"}, 32'(face_up), 0);
      chk({tag, "_matched"}, 32'(matched), 0);
      chk({tag, "_pairs"}, 32'(pairs_found), 0);
      chk({tag, "_moves"}, 32'(moves), 0);
      chk({tag, "_done"}, 32'(game_done), 0);
      chk({tag, "_state"}, 32'(state), 0);
   endtask

   initial begin
      do_reset("rst");

      // cursor wrap
      pulse(0, 0, 0, 1, 0); chk("r1", 32'(cursor), 1);
      pulse(0, 0, 0, 1, 0); chk("r2", 32'(cursor), 2);
      pulse(0, 0, 0, 1, 0); chk("r3", 32'(cursor), 3);
      pulse(0, 0, 0, 1, 0); chk("r4", 32'(cursor), 0);
      pulse(0, 1, 0, 0, 0); chk("down", 32'(cursor), 4);
      pulse(1, 0, 0, 0, 0); chk("up4", 32'(cursor), 0);
      pulse(1, 0, 0, 0, 0); chk("up0", 32'(cursor), 12);
      pulse(0, 1, 0, 0, 0); chk("down12", 32'(cursor), 0);
      pulse(0, 0, 1, 0, 0); chk("left0", 32'(cursor), 3);
      pulse(0, 0, 0, 1, 0); chk("right3", 32'(cursor), 0);
      pulse(1, 0, 0, 1, 0); chk("up_right", 32'(cursor), 12);
      pulse(0, 1, 0, 0, 0); chk("back0", 32'(cursor), 0);
      exp_cur = 0;

      // match 0/8
      sel();
      chk("m_face1", 32'(face_up), 32'h0001);
      chk("m_state1", 32'(state), 1);
      go_to(8);
      sel();
      chk("m_face2", 32'(face_up), 32'h0101);
      chk("m_cmp", 32'(state), 2);
      tick();
      chk("m_matched", 32'(matched), 32'h0101);
      chk("m_pairs", 32'(pairs_found), 1);
      chk("m_moves", 32'(moves), 1);
      chk("m_idle", 32'(state), 0);

      // ignored selects
      sel();
      chk("ig8_face", 32'(face_up), 32'h0101);
      chk("ig8_state", 32'(state), 0);
      go_to(1);
      sel();
      chk("ig_first", 32'(face_up), 32'h0103);
      sel();
      chk("ig_same_face", 32'(face_up), 32'h0103);
      chk("ig_same_state", 32'(state), 1);
      chk("ig_same_moves", 32'(moves), 1);
      pulse(0, 0, 1, 0, 0);
      exp_cur = 0;
      sel();
      chk("ig_match_face", 32'(face_up), 32'h0103);
      chk("ig_match_state", 32'(state), 1);

      // mismatch 1/2, second select at cycle n
      go_to(2);
      sel();
      chk("mm_face", 32'(face_up), 32'h0107);
      chk("mm_cmp", 32'(state), 2);
      chk("mm_moves_n1", 32'(moves), 1);
      tick();
      chk("mm_hold", 32'(state), 3);
      chk("mm_moves", 32'(moves), 2);
      chk("mm_matched", 32'(matched), 32'h0101);
      pulse(0, 0, 0, 1, 0);
      exp_cur = 3;
      chk("mm_hold_move", 32'(cursor), 3);
      sel();
      chk("mm_hold_sel_face", 32'(face_up), 32'h0107);
      chk("mm_hold_sel_state", 32'(state), 3);
      repeat (H - 3) tick();
      chk("mm_last_face", 32'(face_up), 32'h0107);
      chk("mm_last_state", 32'(state), 3);
      tick();
      chk("mm_clear_face", 32'(face_up), 32'h0101);
      chk("mm_clear_state", 32'(state), 0);

      // reset mid-HOLD
      sel();
      pulse(0, 0, 1, 0, 0);
      exp_cur = 2;
      sel();
      tick();
      chk("rh_in_hold", 32'(state), 3);
      do_reset("rst_hold");

      // full game
      for (int p = 0; p < 8; p++) begin
         go_to(p);
         sel();
         go_to(p + 8);
         sel();
         tick();
      end
      chk("g_pairs", 32'(pairs_found), 8);
      chk("g_face", 32'(face_up), 32'hFFFF);
      chk("g_matched", 32'(matched), 32'hFFFF);
      chk("g_moves", 32'(moves), 8);
      chk("g_done", 32'(game_done), 1);
      chk("g_state", 32'(state), 4);
      pulse(0, 0, 0, 1, 0);
      chk("g_move_ign", 32'(cursor), 15);
      sel();
      chk("rs_face", 32'(face_up), 0);
      chk("rs_matched", 32'(matched), 0);
      chk("rs_pairs", 32'(pairs_found), 0);
      chk("rs_moves", 32'(moves), 0);
      chk("rs_done", 32'(game_done), 0);
      chk("rs_state", 32'(state), 0);
      chk("rs_cursor", 32'(cursor), 15);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
